// File: rtl/param_data_memory.sv
// Parametrised data memory: 1-cycle registered read with write-first bypass, post-reset clear sweep.
// Backpressure: busy is high for DEPTH edges after reset; requests then are dropped and raise sticky err.
module param_data_memory #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 256,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              rvalid,
    output logic              busy,
    output logic              err
);

    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PTR_W-1:0]  ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              w_in_range;
    logic              r_in_range;
    logic              wr_ok;
    logic              rd_ok;
    logic              bypass;
    logic              bad_access;
    logic [PTR_W-1:0]  widx;
    logic [PTR_W-1:0]  ridx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_CLEAR && ptr == PTR_LAST) begin
            state_nxt = S_READY;
        end
    end

    always_comb begin
        busy = (state == S_CLEAR);
    end

    // Range checks on the full address so no aliasing when DEPTH < 2**ADDR_W.
    always_comb begin
        w_in_range = {1'b0, waddr} < DEPTH_X;
        r_in_range = {1'b0, raddr} < DEPTH_X;
        wr_ok      = !busy && we && w_in_range;
        rd_ok      = !busy && re && r_in_range;
        bypass     = wr_ok && (waddr == raddr);
        bad_access = busy ? (re || we)
                          : ((we && !w_in_range) || (re && !r_in_range));
        widx       = waddr[PTR_W-1:0];
        ridx       = raddr[PTR_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr    <= '0;
            dout   <= '0;
            rvalid <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (busy && ptr != PTR_LAST) begin
                ptr <= ptr + PTR_W'(1);
            end
            rvalid <= rd_ok;
            if (rd_ok) begin
                dout <= bypass ? din : mem[ridx];
            end
            if (bad_access) begin
                err <= 1'b1;
            end
        end
    end

    // Storage has no reset of its own; the clear sweep initialises it.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (busy) begin
                mem[ptr] <= CLEAR_VAL;
            end else if (wr_ok) begin
                mem[widx] <= din;
            end
        end
    end

endmodule
